// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with valid/ready handshake, stall, redirect, trap and halt.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0080,
  parameter int              INC        = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            halt_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            fetch_valid_o,
  output logic            misalign_o
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2;
  logic [1:0] state, state_nx;
  logic [XLEN-1:0] pc_nx, jump_pc;
  logic active, jump, misaligned, hold, mis_nx;
  always_comb begin
    active     = state != BOOT;
    misaligned = redirect_i && |redirect_target_i[ALIGN_BITS-1:0];
    jump       = trap_i || redirect_i;
    jump_pc    = (trap_i || misaligned) ? TRAP_VEC : redirect_target_i;
    hold       = state == HALT || halt_i || stall_i || !fetch_ready_i;
    pc_nx      = !active ? pc_o : jump ? jump_pc : hold ? pc_o : pc_plus_o;
    state_nx   = !active || jump ? RUN : (state == HALT || halt_i) ? HALT : RUN;
    mis_nx     = active && !trap_i && misaligned;
  end
  // BOOT ignores every input; trap/redirect leave HALT with the same priority as in RUN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= BOOT;
      pc_o       <= RESET_VEC;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_nx;
      pc_o       <= pc_nx;
      misalign_o <= mis_nx;
    end
  assign pc_plus_o     = pc_o + XLEN'(INC);
  assign fetch_valid_o = state == RUN;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; second instance covers address wrap.
module tb_pc_gen;
  logic clk = 0, rst = 1, rst2 = 1;
  logic stall_i = 0, redirect_i = 0, trap_i = 0, halt_i = 0, fetch_ready_i = 0;
  logic [31:0] redirect_target_i = '0;
  logic [31:0] pc_o, pc_plus_o, pc2, pc_plus2;
  logic fetch_valid_o, misalign_o, valid2, mis2;
  int checks = 0, errors = 0;
  typedef struct { logic sel; logic [31:0] pc; logic v; logic m; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .trap_i(trap_i), .halt_i(halt_i),
    .fetch_ready_i(fetch_ready_i), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
    .fetch_valid_o(fetch_valid_o), .misalign_o(misalign_o)
  );

  pc_gen #(.RESET_VEC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_target_i(32'h0), .trap_i(1'b0), .halt_i(1'b0),
    .fetch_ready_i(1'b1), .pc_o(pc2), .pc_plus_o(pc_plus2),
    .fetch_valid_o(valid2), .misalign_o(mis2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares the outputs after each edge against the oldest expectation
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.sel) begin
        chk("pc2", pc2, e.pc);
        chk("pc_plus2", pc_plus2, e.pc + 32'd4);
        chk("valid2", {31'd0, valid2}, {31'd0, e.v});
        chk("misalign2", {31'd0, mis2}, {31'd0, e.m});
      end else begin
        chk("pc", pc_o, e.pc);
        chk("pc_plus", pc_plus_o, e.pc + 32'd4);
        chk("valid", {31'd0, fetch_valid_o}, {31'd0, e.v});
        chk("misalign", {31'd0, misalign_o}, {31'd0, e.m});
      end
    end
  end

  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt, input logic tr,
                     input logic hl, input logic rdy, input logic [31:0] pc, input logic v, input logic m);
    stall_i = st; redirect_i = rd; redirect_target_i = tgt; trap_i = tr; halt_i = hl; fetch_ready_i = rdy;
    q.push_back('{1'b0, pc, v, m});
    @(negedge clk);
  endtask

  task automatic cyc2(input logic [31:0] pc);
    q.push_back('{1'b1, pc, 1'b1, 1'b0});
    @(negedge clk);
  endtask

  initial begin
    q.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    q.push_back('{1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;
    // sequential fetch
    cyc(0, 0, 0, 0, 0, 1, 32'h00, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h04, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h08, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0C, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    // not-ready then stall hold the PC
    cyc(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h14, 1, 0);
    // redirect without ready, trap beats redirect
    cyc(0, 1, 32'h100, 0, 0, 0, 32'h100, 1, 0);
    cyc(0, 1, 32'h140, 1, 0, 1, 32'h80, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h84, 1, 0);
    // misaligned redirect
    cyc(0, 1, 32'h102, 0, 0, 1, 32'h80, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h84, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h88, 1, 0);
    // halt wins over stall, HALT ignores handshake, redirect resumes
    cyc(0, 1, 32'h20, 0, 0, 1, 32'h20, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 32'h20, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h20, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    cyc(0, 1, 32'h200, 0, 0, 0, 32'h200, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h204, 1, 0);
    // asynchronous reset mid-cycle
    #2 rst = 1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_valid", {31'd0, fetch_valid_o}, 32'd0);
    @(negedge clk);
    rst = 0;
    // halt in BOOT is ignored
    cyc(0, 0, 0, 0, 1, 1, 32'h0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h4, 1, 0);
    // wrap-around on the second instance
    rst2 = 0;
    cyc2(32'hFFFF_FFF8);
    cyc2(32'hFFFF_FFFC);
    cyc2(32'h0000_0000);
    cyc2(32'h0000_0004);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
